// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG transmit scheduler.
// Holds message geometry, header codes, source encodings and FSM states.
package ipg_pkg;

  localparam int HDR_WIDTH = 8;
  localparam int MSG_WIDTH = 584;
  localparam int LEN_W     = 10;

  localparam logic [HDR_WIDTH-1:0] READ_REQ  = 8'd0;
  localparam logic [HDR_WIDTH-1:0] WRITE_REQ = 8'd1;

  localparam logic SRC_REP = 1'b0;
  localparam logic SRC_REQ = 1'b1;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

endpackage

// File: rtl/ipg_chunker.sv
// Shift register + remaining-bit counter that slices a latched message
// MSB-first into chunks of up to 64 bits.
// Ports: clk, rst (sync, active-high), i_load/i_msg/i_len latch a message,
// i_adv consumes o_n bits, i_avail is the PHY budget; o_n, o_chunk, o_last.
module ipg_chunker
  import ipg_pkg::*;
#(
  parameter int MW = MSG_WIDTH,
  parameter int LW = LEN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [MW-1:0] i_msg,
  input  logic [LW-1:0] i_len,
  input  logic          i_adv,
  input  logic [6:0]    i_avail,
  output logic [6:0]    o_n,
  output logic [63:0]   o_chunk,
  output logic          o_last
);

  logic [MW-1:0] r_sr;
  logic [LW-1:0] r_rem;
  logic [6:0]    w_a;
  logic [LW-1:0] w_a_ext;
  logic [LW-1:0] w_n_ext;
  logic [63:0]   w_mask;

  assign w_a     = (i_avail > 7'd64) ? 7'd64 : i_avail;
  assign w_a_ext = {{(LW-7){1'b0}}, w_a};
  assign o_n     = (w_a_ext < r_rem) ? w_a : r_rem[6:0];
  assign w_n_ext = {{(LW-7){1'b0}}, o_n};

  // Keep only the top n bits; a shift by 64 yields an all-ones mask.
  assign w_mask  = ~({64{1'b1}} >> o_n);
  assign o_chunk = r_sr[MW-1 -: 64] & w_mask;
  assign o_last  = (o_n != 7'd0) && (w_n_ext == r_rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_sr  <= i_msg;
      r_rem <= i_len;
    end else if (i_adv) begin
      r_sr  <= r_sr << o_n;
      r_rem <= r_rem - w_n_ext;
    end
  end

endmodule

// File: rtl/ipg_tx_sched.sv
// Arbitrates reply/request queues and streams one message at a time
// into the PHY IPG side channel. Macro IPG_SCHED_RR_EN selects round-robin.
// Ports: rep_*/req_* valid/ready message inputs, ipg_avail budget,
// tx_ipg_data/tx_len/tx_sof/tx_eof/tx_src registered chunk outputs, busy.
module ipg_tx_sched
  import ipg_pkg::*;
#(
  parameter int MSG_WIDTH = ipg_pkg::MSG_WIDTH,
  parameter int LEN_W     = ipg_pkg::LEN_W,
  parameter int HDR_WIDTH = ipg_pkg::HDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rep_valid,
  output logic                 rep_ready,
  input  logic [MSG_WIDTH-1:0] rep_msg,
  input  logic [LEN_W-1:0]     rep_len,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MSG_WIDTH-1:0] req_msg,
  input  logic [LEN_W-1:0]     req_len,
  input  logic [6:0]           ipg_avail,
  output logic [63:0]          tx_ipg_data,
  output logic [6:0]           tx_len,
  output logic                 tx_sof,
  output logic                 tx_eof,
  output logic                 tx_src,
  output logic                 busy
);

  state_e                r_state;
  logic                  r_first;
  logic                  w_win;
  logic                  w_acc;
  logic [MSG_WIDTH-1:0]  w_msg;
  logic [LEN_W-1:0]      w_len;
  logic [6:0]            w_n;
  logic [63:0]           w_chunk;
  logic                  w_last;

`ifdef IPG_SCHED_RR_EN
  logic r_ptr;
  assign w_win = (rep_valid && req_valid) ? r_ptr :
                 (rep_valid ? SRC_REP : SRC_REQ);
`else
  assign w_win = rep_valid ? SRC_REP : SRC_REQ;
`endif

  // Ready is only offered from IDLE, so it can never overlap busy.
  assign w_acc     = (r_state == IDLE) && (rep_valid || req_valid);
  assign rep_ready = w_acc && (w_win == SRC_REP);
  assign req_ready = w_acc && (w_win == SRC_REQ);
  assign w_msg     = (w_win == SRC_REQ) ? req_msg : rep_msg;
  assign w_len     = (w_win == SRC_REQ) ? req_len : rep_len;

  ipg_chunker #(
    .MW (MSG_WIDTH),
    .LW (LEN_W)
  ) u_chunker (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_acc),
    .i_msg   (w_msg),
    .i_len   (w_len),
    .i_adv   (r_state == SEND),
    .i_avail (ipg_avail),
    .o_n     (w_n),
    .o_chunk (w_chunk),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_first     <= 1'b0;
      tx_ipg_data <= '0;
      tx_len      <= '0;
      tx_sof      <= 1'b0;
      tx_eof      <= 1'b0;
      tx_src      <= 1'b0;
      busy        <= 1'b0;
`ifdef IPG_SCHED_RR_EN
      r_ptr       <= SRC_REP;
`endif
    end else begin
      tx_ipg_data <= '0;
      tx_len      <= '0;
      tx_sof      <= 1'b0;
      tx_eof      <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            tx_src  <= w_win;
            r_first <= 1'b1;
`ifdef IPG_SCHED_RR_EN
            r_ptr   <= ~w_win;
`endif
            // Zero-length messages are consumed without leaving IDLE.
            if (w_len != '0) begin
              r_state <= SEND;
              busy    <= 1'b1;
            end
          end
        end
        SEND: begin
          if (w_n != 7'd0) begin
            tx_ipg_data <= w_chunk;
            tx_len      <= w_n;
            tx_sof      <= r_first;
            tx_eof      <= w_last;
            r_first     <= 1'b0;
            if (w_last) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipg_tx_sched.sv
// Scoreboard bench for ipg_tx_sched: directed messages with expected
// chunks queued at issue time and checked by an output monitor.
module tb_ipg_tx_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         rep_valid, req_valid;
  logic         rep_ready, req_ready;
  logic [583:0] rep_msg, req_msg;
  logic [9:0]   rep_len, req_len;
  logic [6:0]   ipg_avail;
  logic [63:0]  tx_ipg_data;
  logic [6:0]   tx_len;
  logic         tx_sof, tx_eof, tx_src, busy;

  typedef struct {
    logic [63:0] d;
    logic [6:0]  l;
    logic        s;
    logic        e;
    logic        src;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   req_rdy_cnt = 0;

  always #5 clk = ~clk;

  ipg_tx_sched dut (
    .clk         (clk),
    .rst         (rst),
    .rep_valid   (rep_valid),
    .rep_ready   (rep_ready),
    .rep_msg     (rep_msg),
    .rep_len     (rep_len),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_msg     (req_msg),
    .req_len     (req_len),
    .ipg_avail   (ipg_avail),
    .tx_ipg_data (tx_ipg_data),
    .tx_len      (tx_len),
    .tx_sof      (tx_sof),
    .tx_eof      (tx_eof),
    .tx_src      (tx_src),
    .busy        (busy)
  );

  function automatic void push(input logic [63:0] d, input logic [6:0] l,
                               input logic s, input logic e,
                               input logic src);
    exp_t x;
    x.d = d; x.l = l; x.s = s; x.e = e; x.src = src;
    q.push_back(x);
  endfunction

  function automatic logic [583:0] mkmsg();
    logic [583:0] m;
    m = '0;
    for (int i = 0; i < 19; i++) m = {m[551:0], $urandom()};
    return m;
  endfunction

  // Monitor: compares every presented chunk with the scoreboard head.
  always @(negedge clk) begin
    if (req_ready) req_rdy_cnt++;
    if (rep_ready || req_ready) begin
      checks++;
      if ((rep_ready && req_ready) || busy) begin
        errs++;
        $display("FAIL ready_excl rep=%b req=%b busy=%b",
                 rep_ready, req_ready, busy);
      end
    end
    if (tx_len != 7'd0) begin
      checks++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_chunk len=%0d data=%h", tx_len, tx_ipg_data);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (tx_ipg_data !== x.d || tx_len !== x.l || tx_sof !== x.s ||
            tx_eof !== x.e || tx_src !== x.src) begin
          errs++;
          $display("FAIL chunk got d=%h l=%0d s=%b e=%b src=%b exp d=%h l=%0d s=%b e=%b src=%b",
                   tx_ipg_data, tx_len, tx_sof, tx_eof, tx_src,
                   x.d, x.l, x.s, x.e, x.src);
        end
      end
      if (!tx_eof) begin
        checks++;
        if (busy !== 1'b1) begin
          errs++;
          $display("FAIL busy_mid got=%b exp=1", busy);
        end
      end
    end
  end

  task automatic offer(input logic src, input logic [583:0] m,
                       input logic [9:0] l);
    bit got;
    if (src) begin
      req_msg = m; req_len = l; req_valid = 1'b1;
    end else begin
      rep_msg = m; rep_len = l; rep_valid = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (src ? req_ready : rep_ready) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errs++;
      $display("FAIL handshake_timeout src=%b got=0 exp=1", src);
    end
    @(posedge clk);
    #1;
    if (src) req_valid = 1'b0;
    else rep_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errs++;
      $display("FAIL drain_timeout pending=%0d exp=0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  logic [583:0] m, m2;
  int           rc;
  logic [6:0]   pat[6];
  bit           quiet;

  initial begin
    rst = 1'b1;
    rep_valid = 1'b0; req_valid = 1'b0;
    rep_msg = '0; req_msg = '0; rep_len = '0; req_len = '0;
    ipg_avail = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data", tx_ipg_data, 64'd0);
    chk("reset_ctl", {tx_len, tx_sof, tx_eof, tx_src, busy}, 64'd0);
    chk("reset_ready", {rep_ready, req_ready}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reply, 72 bits at 16 bits/cycle.
    m = mkmsg();
    for (int k = 0; k < 4; k++)
      push({m[583-16*k -: 16], 48'd0}, 7'd16, k == 0, 1'b0, 1'b0);
    push({m[519:512], 56'd0}, 7'd8, 1'b0, 1'b1, 1'b0);
    ipg_avail = 7'd16;
    offer(1'b0, m, 10'd72);
    drain();

    // Full-length request at 64 bits/cycle.
    m = mkmsg();
    for (int k = 0; k < 9; k++)
      push(m[583-64*k -: 64], 7'd64, k == 0, 1'b0, 1'b1);
    push({m[7:0], 56'd0}, 7'd8, 1'b0, 1'b1, 1'b1);
    ipg_avail = 7'd64;
    rc = req_rdy_cnt;
    offer(1'b1, m, 10'd584);
    drain();
    chk("req_ready_pulses", 64'(req_rdy_cnt - rc), 64'd1);

    // Simultaneous offers: reply wins, request follows.
    m = mkmsg();
    m2 = mkmsg();
    push({m[583:568], 48'd0}, 7'd16, 1'b1, 1'b1, 1'b0);
    push({m2[583:544], 24'd0}, 7'd40, 1'b1, 1'b1, 1'b1);
    ipg_avail = 7'd64;
    fork
      offer(1'b0, m, 10'd16);
      offer(1'b1, m2, 10'd40);
    join
    drain();

    // Budget above 64 is clamped.
    m = mkmsg();
    push(m[583:520], 7'd64, 1'b1, 1'b0, 1'b0);
    push({m[519:512], 56'd0}, 7'd8, 1'b0, 1'b1, 1'b0);
    ipg_avail = 7'd100;
    offer(1'b0, m, 10'd72);
    drain();

    // Stall / variable budget on a 20-bit request.
    m = mkmsg();
    push({m[583:577], 57'd0}, 7'd7, 1'b1, 1'b0, 1'b1);
    push({m[576:564], 51'd0}, 7'd13, 1'b0, 1'b1, 1'b1);
    pat[0] = 7'd0; pat[1] = 7'd0; pat[2] = 7'd7;
    pat[3] = 7'd0; pat[4] = 7'd100; pat[5] = 7'd3;
    ipg_avail = 7'd0;
    offer(1'b1, m, 10'd20);
    for (int i = 0; i < 6; i++) begin
      ipg_avail = pat[i];
      @(negedge clk);
      if (i == 1) chk("stall", {tx_len, busy}, {56'd0, 7'd0, 1'b1});
      @(posedge clk);
      #1;
    end
    drain();

    // Zero-length message is consumed silently.
    ipg_avail = 7'd16;
    offer(1'b0, mkmsg(), 10'd0);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (busy || tx_len != 0 || tx_sof || tx_eof) quiet = 1'b0;
    end
    chk("zero_len_quiet", {63'd0, quiet}, 64'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a 72-bit request.
    m = mkmsg();
    push({m[583:568], 48'd0}, 7'd16, 1'b1, 1'b0, 1'b1);
    push({m[567:552], 48'd0}, 7'd16, 1'b0, 1'b0, 1'b1);
    ipg_avail = 7'd16;
    offer(1'b1, m, 10'd72);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_data", tx_ipg_data, 64'd0);
    chk("midrst_ctl", {tx_len, tx_sof, tx_eof, tx_src, busy}, 64'd0);
    chk("midrst_pending", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m = mkmsg();
    for (int k = 0; k < 4; k++)
      push({m[583-16*k -: 16], 48'd0}, 7'd16, k == 0, 1'b0, 1'b0);
    push({m[519:512], 56'd0}, 7'd8, 1'b0, 1'b1, 1'b0);
    offer(1'b0, m, 10'd72);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
